execute_stage: RTL and testbench

Execute stage of the Y86-64 pipeline. It sits directly downstream of the E pipeline register. It computes the ALU result, the branch/cmov condition and the CC register update, and it drives the forwarding signals `e_valE`/`e_dstE`/`e_Cnd` to decode and the pipeline control logic. It also owns the M pipeline register that feeds the memory stage.

---
 rtl/y86_pkg.sv | 54 +++++
 rtl/alu.sv | 34 +++
 rtl/execute_stage.sv | 126 ++++++++++++
 tb/tb_execute_stage.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU functions, branch conditions,
// status codes and the condition-code register layout.
package y86_pkg;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alufun_e;

  typedef enum logic [3:0] {
    C_YES = 4'h0,
    C_LE  = 4'h1,
    C_L   = 4'h2,
    C_E   = 4'h3,
    C_NE  = 4'h4,
    C_GE  = 4'h5,
    C_G   = 4'h6
  } cond_e;

  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_ADR = 2'd2,
    STAT_INS = 2'd3
  } stat_e;

  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

endpackage

// File: rtl/alu.sv
// Y86-64 ALU: computes aluB op aluA and the resulting flags; purely combinational.
module alu
  import y86_pkg::*;
(
  input  logic [63:0] i_alua,
  input  logic [63:0] i_alub,
  input  alufun_e     i_alufun,
  output logic [63:0] o_vale,
  output logic        o_zf,
  output logic        o_sf,
  output logic        o_of
);

  always_comb begin
    o_vale = '0;
    o_of   = 1'b0;
    case (i_alufun)
      ALU_ADD: begin
        o_vale = i_alub + i_alua;
        o_of   = (i_alua[63] == i_alub[63]) && (o_vale[63] != i_alua[63]);
      end
      ALU_SUB: begin
        o_vale = i_alub - i_alua;
        o_of   = (i_alua[63] != i_alub[63]) && (o_vale[63] != i_alub[63]);
      end
      ALU_AND: o_vale = i_alub & i_alua;
      ALU_XOR: o_vale = i_alub ^ i_alua;
      default: o_vale = i_alub + i_alua;
    endcase
    o_zf = (o_vale == '0);
    o_sf = o_vale[63];
  end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU operand selection, CC register, branch/cmov condition,
// forwarding outputs and the M pipeline register.
module execute_stage
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  E_stat,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  E_ifun,
  input  logic [63:0] E_valC,
  input  logic [63:0] E_valA,
  input  logic [63:0] E_valB,
  input  logic [3:0]  E_dstE,
  input  logic [3:0]  E_dstM,
  input  logic [1:0]  m_stat,
  input  logic [1:0]  W_stat,
  input  logic        M_bubble,
  output logic [63:0] e_valE,
  output logic [3:0]  e_dstE,
  output logic        e_Cnd,
  output logic [1:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_Cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM
);

  logic [63:0] w_alua;
  logic [63:0] w_alub;
  alufun_e     w_alufun;
  logic        w_zf;
  logic        w_sf;
  logic        w_of;
  logic        w_set_cc;
  logic        w_lt;
  cc_t         r_cc;

  always_comb begin
    w_alua = '0;
    case (E_icode)
      I_RRMOVQ, I_OPQ:             w_alua = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: w_alua = E_valC;
      I_CALL, I_PUSHQ:             w_alua = 64'hFFFF_FFFF_FFFF_FFF8;
      I_RET, I_POPQ:               w_alua = 64'd8;
      default:                     w_alua = '0;
    endcase
  end

  always_comb begin
    w_alub = '0;
    case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: w_alub = E_valB;
      default:                                                  w_alub = '0;
    endcase
  end

  // Only OPq selects the ALU function; undefined OPq ifun values fall back to add.
  always_comb begin
    w_alufun = ALU_ADD;
    if (E_icode == I_OPQ && E_ifun <= 4'd3)
      w_alufun = alufun_e'(E_ifun[1:0]);
  end

  alu u_alu (
    .i_alua   (w_alua),
    .i_alub   (w_alub),
    .i_alufun (w_alufun),
    .o_vale   (e_valE),
    .o_zf     (w_zf),
    .o_sf     (w_sf),
    .o_of     (w_of)
  );

  // Exceptions further down the pipe must not let a younger OPq modify CC.
  assign w_set_cc = (E_icode == I_OPQ) && (E_stat == STAT_AOK) &&
                    (m_stat == STAT_AOK) && (W_stat == STAT_AOK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cc <= CC_RESET;
    else if (w_set_cc)
      r_cc <= '{zf: w_zf, sf: w_sf, of: w_of};
  end

  assign w_lt = r_cc.sf ^ r_cc.of;

  always_comb begin
    e_Cnd = 1'b0;
    case (E_ifun)
      C_YES:   e_Cnd = 1'b1;
      C_LE:    e_Cnd = w_lt | r_cc.zf;
      C_L:     e_Cnd = w_lt;
      C_E:     e_Cnd = r_cc.zf;
      C_NE:    e_Cnd = !r_cc.zf;
      C_GE:    e_Cnd = !w_lt;
      C_G:     e_Cnd = !w_lt && !r_cc.zf;
      default: e_Cnd = 1'b0;
    endcase
  end

  assign e_dstE = (E_icode == I_RRMOVQ && !e_Cnd) ? RNONE : E_dstE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || M_bubble) begin
      M_stat  <= STAT_AOK;
      M_icode <= I_HALT;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else begin
      M_stat  <= E_stat;
      M_icode <= E_icode;
      M_Cnd   <= e_Cnd;
      M_valE  <= e_valE;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios plus randomized
// traffic compared against a flag/arithmetic reference model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  E_stat, m_stat, W_stat;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
  logic [63:0] E_valC, E_valA, E_valB;
  logic        M_bubble;
  logic [63:0] e_valE;
  logic [3:0]  e_dstE;
  logic        e_Cnd;
  logic [1:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE, M_valA;
  logic [3:0]  M_dstE, M_dstM;

  int errors = 0;
  int checks = 0;

  bit mzf, msf, mof;
  logic [1:0]  xm_stat;
  logic [3:0]  xm_icode, xm_dstE, xm_dstM;
  logic        xm_cnd;
  logic [63:0] xm_valE, xm_valA;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_stat(m_stat), .W_stat(W_stat), .M_bubble(M_bubble),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
    .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
  );

  always #5 clk = ~clk;

  // Reference: operands by instruction class, signed overflow from a 65-bit result.
  function automatic void ref_model(input logic [3:0] ic, input logic [3:0] fn,
                                    input logic [63:0] vc, input logic [63:0] va,
                                    input logic [63:0] vb, input logic [3:0] de,
                                    input bit zf, input bit sf, input bit of,
                                    output logic [63:0] ve, output bit nzf,
                                    output bit nsf, output bit nof,
                                    output bit cnd, output logic [3:0] dst);
    logic [63:0] a, b;
    logic [64:0] w;
    int op;
    bit lt;
    a = 64'd0;
    b = 64'd0;
    if (ic == 2 || ic == 6) a = va;
    else if (ic == 3 || ic == 4 || ic == 5) a = vc;
    else if (ic == 8 || ic == 10) a = 64'd0 - 64'd8;
    else if (ic == 9 || ic == 11) a = 64'd8;
    if (ic inside {4, 5, 6, 8, 9, 10, 11}) b = vb;
    op = (ic == 6 && fn < 4) ? int'(fn) : 0;
    nof = 1'b0;
    ve = 64'd0;
    case (op)
      1: begin w = {b[63], b} - {a[63], a}; ve = w[63:0]; nof = (w[64] != w[63]); end
      2: ve = a & b;
      3: ve = a ^ b;
      default: begin w = {b[63], b} + {a[63], a}; ve = w[63:0]; nof = (w[64] != w[63]); end
    endcase
    nzf = (ve == 64'd0);
    nsf = ve[63];
    lt = sf ^ of;
    case (fn)
      0: cnd = 1'b1;
      1: cnd = lt | zf;
      2: cnd = lt;
      3: cnd = zf;
      4: cnd = !zf;
      5: cnd = !lt;
      6: cnd = !lt && !zf;
      default: cnd = 1'b0;
    endcase
    dst = (ic == 2 && !cnd) ? 4'hF : de;
  endfunction

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(0, 16));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic apply(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] vc,
                       input logic [63:0] va, input logic [63:0] vb,
                       input logic [3:0] de, input logic [3:0] dm, input logic [1:0] st);
    E_icode = ic; E_ifun = fn; E_valC = vc; E_valA = va; E_valB = vb;
    E_dstE = de; E_dstM = dm; E_stat = st;
    #1;
  endtask

  // Advance one clock, keeping the model CC and expected M contents in step.
  task automatic tick();
    logic [63:0] ve;
    bit nzf, nsf, nof, cnd, setcc;
    logic [3:0] dst;
    ref_model(E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, mzf, msf, mof,
              ve, nzf, nsf, nof, cnd, dst);
    setcc = (E_icode == 6) && (E_stat == 0) && (m_stat == 0) && (W_stat == 0);
    if (M_bubble) begin
      xm_stat = 0; xm_icode = 0; xm_cnd = 0; xm_valE = 0; xm_valA = 0;
      xm_dstE = 4'hF; xm_dstM = 4'hF;
    end else begin
      xm_stat = E_stat; xm_icode = E_icode; xm_cnd = cnd; xm_valE = ve;
      xm_valA = E_valA; xm_dstE = dst; xm_dstM = E_dstM;
    end
    @(posedge clk);
    #1;
    if (setcc) begin mzf = nzf; msf = nsf; mof = nof; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    apply(4'h7, 4'h3, 0, 0, 0, 4'hF, 4'hF, 2'd0);
    @(posedge clk); #1;
    checks++; if (e_Cnd !== 1'b1) begin errors++; $display("FAIL reset_cc_zf: got %b want 1", e_Cnd); end
    checks++; if (M_icode !== 4'h0) begin errors++; $display("FAIL reset_M_icode: got %h want 0", M_icode); end
    checks++; if (M_dstE !== 4'hF || M_dstM !== 4'hF) begin errors++; $display("FAIL reset_M_dst: got %h/%h want F/F", M_dstE, M_dstM); end
    rst_n = 1'b1;
    mzf = 1; msf = 0; mof = 0;
    apply(4'h6, 4'h1, 0, 64'd1, 64'd0, 4'h4, 4'hF, 2'd0);
    tick();
    apply(4'h7, 4'h3, 0, 0, 0, 4'hF, 4'hF, 2'd0);
    checks++; if (e_Cnd !== 1'b0) begin errors++; $display("FAIL pre_reset_je: got %b want 0", e_Cnd); end
    checks++; if (M_icode !== 4'h6) begin errors++; $display("FAIL pre_reset_M_icode: got %h want 6", M_icode); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (e_Cnd !== 1'b1) begin errors++; $display("FAIL midrun_reset_cc: got %b want 1", e_Cnd); end
    checks++; if (M_icode !== 4'h0 || M_dstE !== 4'hF || M_dstM !== 4'hF || M_valE !== 64'd0)
      begin errors++; $display("FAIL midrun_reset_M: got icode=%h dstE=%h dstM=%h valE=%h want 0/F/F/0", M_icode, M_dstE, M_dstM, M_valE); end
    mzf = 1; msf = 0; mof = 0;
    #3 rst_n = 1'b1;
  endtask

  task automatic test_sub_jl();
    apply(4'h6, 4'h1, 0, 64'd1, 64'd0, 4'h4, 4'hF, 2'd0);
    checks++; if (e_valE !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL sub_valE: got %h want ffffffffffffffff", e_valE); end
    tick();
    checks++; if (M_valE !== 64'hFFFF_FFFF_FFFF_FFFF || M_icode !== 4'h6 || M_dstE !== 4'h4)
      begin errors++; $display("FAIL sub_M: got valE=%h icode=%h dstE=%h", M_valE, M_icode, M_dstE); end
    apply(4'h7, 4'h2, 0, 0, 0, 4'hF, 4'hF, 2'd0);
    checks++; if (e_Cnd !== 1'b1) begin errors++; $display("FAIL sub_jl: got %b want 1", e_Cnd); end
    apply(4'h7, 4'h3, 0, 0, 0, 4'hF, 4'hF, 2'd0);
    checks++; if (e_Cnd !== 1'b0) begin errors++; $display("FAIL sub_je: got %b want 0", e_Cnd); end
    apply(4'h7, 4'h4, 0, 0, 0, 4'hF, 4'hF, 2'd0);
    checks++; if (e_Cnd !== 1'b1) begin errors++; $display("FAIL sub_jne: got %b want 1", e_Cnd); end
  endtask

  task automatic test_overflow();
    m_stat = 2'd2;
    apply(4'h6, 4'h0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h5, 4'hF, 2'd0);
    checks++; if (e_valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL ovf_valE: got %h want fffffffffffffffe", e_valE); end
    tick();
    m_stat = 2'd0;
    apply(4'h7, 4'h2, 0, 0, 0, 4'hF, 4'hF, 2'd0);
    checks++; if (e_Cnd !== 1'b1) begin errors++; $display("FAIL ovf_suppressed_by_m_stat: got %b want 1", e_Cnd); end
    apply(4'h6, 4'h0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h5, 4'hF, 2'd0);
    tick();
    apply(4'h7, 4'h2, 0, 0, 0, 4'hF, 4'hF, 2'd0);
    checks++; if (e_Cnd !== 1'b0) begin errors++; $display("FAIL ovf_jl: got %b want 0", e_Cnd); end
    apply(4'h7, 4'h6, 0, 0, 0, 4'hF, 4'hF, 2'd0);
    checks++; if (e_Cnd !== 1'b1) begin errors++; $display("FAIL ovf_jg: got %b want 1", e_Cnd); end
    W_stat = 2'd3;
    apply(4'h6, 4'h1, 0, 64'd1, 64'd0, 4'h5, 4'hF, 2'd0);
    tick();
    W_stat = 2'd0;
    apply(4'h7, 4'h2, 0, 0, 0, 4'hF, 4'hF, 2'd0);
    checks++; if (e_Cnd !== 1'b0) begin errors++; $display("FAIL w_stat_suppress: got %b want 0", e_Cnd); end
  endtask

  task automatic test_cmov();
    apply(4'h6, 4'h3, 0, 64'd5, 64'd5, 4'h1, 4'hF, 2'd0);
    tick();
    apply(4'h2, 4'h4, 0, 64'h1234, 64'h9999, 4'h3, 4'hF, 2'd0);
    checks++; if (e_Cnd !== 1'b0 || e_dstE !== 4'hF) begin errors++; $display("FAIL cmovne_zf1: got cnd=%b dstE=%h want 0/F", e_Cnd, e_dstE); end
    tick();
    checks++; if (M_dstE !== 4'hF || M_Cnd !== 1'b0 || M_valE !== 64'h1234)
      begin errors++; $display("FAIL cmovne_zf1_M: got dstE=%h cnd=%b valE=%h want F/0/1234", M_dstE, M_Cnd, M_valE); end
    apply(4'h6, 4'h0, 0, 64'd1, 64'd0, 4'h1, 4'hF, 2'd0);
    tick();
    apply(4'h2, 4'h4, 0, 64'h1234, 64'h9999, 4'h3, 4'hF, 2'd0);
    checks++; if (e_Cnd !== 1'b1 || e_dstE !== 4'h3 || e_valE !== 64'h1234)
      begin errors++; $display("FAIL cmovne_zf0: got cnd=%b dstE=%h valE=%h want 1/3/1234", e_Cnd, e_dstE, e_valE); end
    tick();
    checks++; if (M_dstE !== 4'h3 || M_Cnd !== 1'b1) begin errors++; $display("FAIL cmovne_zf0_M: got dstE=%h cnd=%b want 3/1", M_dstE, M_Cnd); end
  endtask

  task automatic test_stack();
    logic [63:0] ve;
    bit nzf, nsf, nof, cnd;
    logic [3:0] dst;
    apply(4'h6, 4'h3, 0, 64'd9, 64'd9, 4'h1, 4'hF, 2'd0);
    tick();
    apply(4'hA, 4'h0, 0, 64'hAAAA, 64'h100, 4'h4, 4'hF, 2'd0);
    checks++; if (e_valE !== 64'hF8) begin errors++; $display("FAIL pushq_valE: got %h want f8", e_valE); end
    tick();
    checks++; if (M_valA !== 64'hAAAA || M_valE !== 64'hF8) begin errors++; $display("FAIL pushq_M: got valA=%h valE=%h want aaaa/f8", M_valA, M_valE); end
    apply(4'hB, 4'h0, 0, 64'h100, 64'h100, 4'h4, 4'h5, 2'd0);
    checks++; if (e_valE !== 64'h108) begin errors++; $display("FAIL popq_valE: got %h want 108", e_valE); end
    tick();
    checks++; if (M_dstM !== 4'h5) begin errors++; $display("FAIL popq_M_dstM: got %h want 5", M_dstM); end
    for (int f = 0; f < 16; f++) begin
      apply(4'h7, 4'(f), 0, 0, 0, 4'hF, 4'hF, 2'd0);
      ref_model(4'h7, 4'(f), 0, 0, 0, 4'hF, mzf, msf, mof, ve, nzf, nsf, nof, cnd, dst);
      checks++; if (e_Cnd !== cnd || cnd !== (f == 0 || f == 1 || f == 3 || f == 5))
        begin errors++; $display("FAIL stack_cc_unchanged ifun=%0d: got %b want %b", f, e_Cnd, (f == 0 || f == 1 || f == 3 || f == 5)); end
    end
  endtask

  task automatic test_bubble();
    M_bubble = 1'b1;
    apply(4'h3, 4'h0, 64'h55, 0, 0, 4'h2, 4'hF, 2'd0);
    checks++; if (e_valE !== 64'h55) begin errors++; $display("FAIL bubble_comb_valE: got %h want 55", e_valE); end
    tick();
    checks++; if (M_icode !== 4'h0 || M_dstE !== 4'hF || M_valE !== 64'd0 || M_stat !== 2'd0)
      begin errors++; $display("FAIL bubble_M: got icode=%h dstE=%h valE=%h stat=%h", M_icode, M_dstE, M_valE, M_stat); end
    M_bubble = 1'b0;
    tick();
    checks++; if (M_icode !== 4'h3 || M_dstE !== 4'h2 || M_valE !== 64'h55)
      begin errors++; $display("FAIL after_bubble_M: got icode=%h dstE=%h valE=%h want 3/2/55", M_icode, M_dstE, M_valE); end
    M_bubble = 1'b1;
    apply(4'h6, 4'h1, 0, 64'd1, 64'd0, 4'h2, 4'hF, 2'd0);
    tick();
    M_bubble = 1'b0;
    apply(4'h7, 4'h2, 0, 0, 0, 4'hF, 4'hF, 2'd0);
    checks++; if (e_Cnd !== 1'b1 || M_icode !== 4'h0)
      begin errors++; $display("FAIL bubble_cc_update: got cnd=%b icode=%h want 1/0", e_Cnd, M_icode); end
  endtask

  task automatic test_random();
    logic [63:0] ve;
    bit nzf, nsf, nof, cnd;
    logic [3:0] dst;
    for (int n = 0; n < 400; n++) begin
      M_bubble = ($urandom_range(0, 7) == 0);
      m_stat = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      W_stat = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      apply(4'($urandom_range(0, 11)), 4'($urandom_range(0, 15)), rand64(), rand64(), rand64(),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0);
      ref_model(E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, mzf, msf, mof,
                ve, nzf, nsf, nof, cnd, dst);
      checks++; if (e_valE !== ve) begin errors++; $display("FAIL rnd_valE #%0d icode=%h ifun=%h: got %h want %h", n, E_icode, E_ifun, e_valE, ve); end
      checks++; if (e_Cnd !== cnd) begin errors++; $display("FAIL rnd_cnd #%0d ifun=%h: got %b want %b", n, E_ifun, e_Cnd, cnd); end
      checks++; if (e_dstE !== dst) begin errors++; $display("FAIL rnd_dstE #%0d: got %h want %h", n, e_dstE, dst); end
      tick();
      checks++; if (M_stat !== xm_stat || M_icode !== xm_icode || M_Cnd !== xm_cnd)
        begin errors++; $display("FAIL rnd_M_ctl #%0d: got stat=%h icode=%h cnd=%b want %h/%h/%b", n, M_stat, M_icode, M_Cnd, xm_stat, xm_icode, xm_cnd); end
      checks++; if (M_valE !== xm_valE || M_valA !== xm_valA)
        begin errors++; $display("FAIL rnd_M_val #%0d: got valE=%h valA=%h want %h/%h", n, M_valE, M_valA, xm_valE, xm_valA); end
      checks++; if (M_dstE !== xm_dstE || M_dstM !== xm_dstM)
        begin errors++; $display("FAIL rnd_M_dst #%0d: got %h/%h want %h/%h", n, M_dstE, M_dstM, xm_dstE, xm_dstM); end
    end
    M_bubble = 1'b0; m_stat = 2'd0; W_stat = 2'd0;
  endtask

  initial begin
    rst_n = 1'b0;
    M_bubble = 1'b0; m_stat = 2'd0; W_stat = 2'd0;
    E_stat = 2'd0; E_icode = 4'h1; E_ifun = 4'h0;
    E_valC = '0; E_valA = '0; E_valB = '0; E_dstE = 4'hF; E_dstM = 4'hF;
    mzf = 1; msf = 0; mof = 0;
    test_reset();
    test_sub_jl();
    test_overflow();
    test_cmov();
    test_stack();
    test_bubble();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
